// File: rtl/frame_ram_arbiter.sv
// Arbitrates the single-port 24-bit frame RAM between display reads and loader writes.
// Reads win contention, but a write waiting behind MAX_RD_BURST read grants is forced through.
module frame_ram_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 24,
   parameter int READ_LATENCY = 1,
   parameter int MAX_RD_BURST = 8
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              rd_req_in,
   input  logic [ADDR_W-1:0] rd_addr_in,
   output logic              rd_gnt_out,
   output logic [DATA_W-1:0] rd_data_out,
   output logic              rd_valid_out,
   input  logic              wr_req_in,
   input  logic [ADDR_W-1:0] wr_addr_in,
   input  logic [DATA_W-1:0] wr_data_in,
   output logic              wr_gnt_out,
   output logic              ram_enable_out,
   output logic              ram_write_enable_out,
   output logic [ADDR_W-1:0] ram_addr_out,
   output logic [DATA_W-1:0] ram_wdata_out,
   input  logic [DATA_W-1:0] ram_rdata_in,
   output logic [15:0]       wr_stall_count_out
);

   localparam int         VLD_LEN     = 1 + READ_LATENCY;
   localparam logic [7:0] BURST_LIMIT = 8'(MAX_RD_BURST);

   logic [7:0]         streak;
   logic               wr_force;
   logic               rd_issue_p0;
   logic [VLD_LEN-1:0] vld_p1;

   always_comb begin
      wr_force   = (streak == BURST_LIMIT);
      wr_gnt_out = 1'b0;
      rd_gnt_out = 1'b0;
      if (!reset_in) begin
         wr_gnt_out = wr_req_in && (!rd_req_in || wr_force);
         rd_gnt_out = rd_req_in && !wr_gnt_out;
      end
   end

   // Read grants accumulated while a write is waiting; any write grant or idle writer clears it.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         streak <= '0;
      end else if (!wr_req_in || wr_gnt_out) begin
         streak <= '0;
      end else if (rd_gnt_out) begin
         streak <= streak + 8'd1;
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         wr_stall_count_out <= '0;
      end else if (wr_req_in && !wr_gnt_out && (wr_stall_count_out != 16'hFFFF)) begin
         wr_stall_count_out <= wr_stall_count_out + 16'd1;
      end
   end

   // p0: registered RAM port, one access per cycle
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         ram_enable_out       <= 1'b0;
         ram_write_enable_out <= 1'b0;
         ram_addr_out         <= '0;
         ram_wdata_out        <= '0;
      end else begin
         ram_enable_out       <= rd_gnt_out | wr_gnt_out;
         ram_write_enable_out <= wr_gnt_out;
         if (wr_gnt_out) begin
            ram_addr_out  <= wr_addr_in;
            ram_wdata_out <= wr_data_in;
         end else if (rd_gnt_out) begin
            ram_addr_out <= rd_addr_in;
         end
      end
   end

   // p1: read marker follows the RAM sampling edge through READ_LATENCY more clocks
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         rd_issue_p0 <= 1'b0;
         vld_p1      <= '0;
      end else begin
         rd_issue_p0 <= rd_gnt_out;
         vld_p1      <= {vld_p1[VLD_LEN-2:0], rd_issue_p0};
      end
   end

   assign rd_valid_out = vld_p1[VLD_LEN-1];
   assign rd_data_out  = ram_rdata_in;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Randomized self-checking bench for frame_ram_arbiter with a behavioural RAM and arbitration model.
module tb_frame_ram_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 24;
   localparam int RL     = 1;
   localparam int MAXB   = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rd_req = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic              rd_gnt;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              wr_req = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_gnt;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic [15:0]       stall;

   always #5 clk = ~clk;

   frame_ram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL), .MAX_RD_BURST(MAXB)
   ) dut (
      .clk_in(clk), .reset_in(rst),
      .rd_req_in(rd_req), .rd_addr_in(rd_addr), .rd_gnt_out(rd_gnt),
      .rd_data_out(rd_data), .rd_valid_out(rd_valid),
      .wr_req_in(wr_req), .wr_addr_in(wr_addr), .wr_data_in(wr_data), .wr_gnt_out(wr_gnt),
      .ram_enable_out(ram_en), .ram_write_enable_out(ram_we), .ram_addr_out(ram_addr),
      .ram_wdata_out(ram_wdata), .ram_rdata_in(ram_rdata), .wr_stall_count_out(stall)
   );

   // Write-first RAM: samples its port on a clock, data valid RL clocks later.
   logic [DATA_W-1:0] ram_mem [0:65535];
   logic [DATA_W-1:0] ram_q   [0:RL];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
            ram_q[0]          <= ram_wdata;
         end else begin
            ram_q[0] <= ram_mem[ram_addr];
         end
      end
      for (int i = 1; i <= RL; i++) ram_q[i] <= ram_q[i-1];
   end
   assign ram_rdata = ram_q[RL];

   int                errors = 0;
   int                checks = 0;
   int                cyc = 0;
   int                streak_m = 0;
   int                stall_m = 0;
   logic              exp_en = 1'b0;
   logic              exp_we = 1'b0;
   logic [ADDR_W-1:0] exp_addr = '0;
   logic [DATA_W-1:0] exp_wdata = '0;
   logic [DATA_W-1:0] shadow [0:65535];
   logic [DATA_W-1:0] q_data[$];
   int                q_due[$];
   bit                acc_rd, acc_wr;
   bit                seen_wr, seen_valid, seen_en;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      streak_m  = 0;
      stall_m   = 0;
      exp_en    = 1'b0;
      exp_we    = 1'b0;
      exp_addr  = '0;
      exp_wdata = '0;
      q_data.delete();
      q_due.delete();
   endtask

   // One clock: check everything against the model just before the edge, then advance the model.
   task automatic tick();
      bit eg_rd, eg_wr, exp_v;
      @(negedge clk);
      eg_wr = wr_req && (!rd_req || streak_m == MAXB);
      eg_rd = rd_req && !eg_wr;
      exp_v = (q_due.size() > 0) && (q_due[0] == cyc);
      seen_wr    = wr_gnt;
      seen_valid = rd_valid;
      seen_en    = ram_en;
      check("rd_gnt", 32'(rd_gnt), 32'(eg_rd));
      check("wr_gnt", 32'(wr_gnt), 32'(eg_wr));
      check("ram_en", 32'(ram_en), 32'(exp_en));
      check("ram_we", 32'(ram_we), 32'(exp_we));
      check("ram_addr", 32'(ram_addr), 32'(exp_addr));
      check("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
      check("stall", 32'(stall), 32'(stall_m));
      check("rd_valid", 32'(rd_valid), 32'(exp_v));
      if (exp_v) begin
         check("rd_data", 32'(rd_data), 32'(q_data[0]));
         void'(q_data.pop_front());
         void'(q_due.pop_front());
      end
      @(posedge clk);
      cyc++;
      acc_rd = eg_rd;
      acc_wr = eg_wr;
      if (wr_req && !eg_wr && stall_m < 65535) stall_m++;
      if (!wr_req || eg_wr) streak_m = 0;
      else if (eg_rd)       streak_m++;
      exp_en = eg_rd | eg_wr;
      exp_we = eg_wr;
      if (eg_wr) begin
         exp_addr        = wr_addr;
         exp_wdata       = wr_data;
         shadow[wr_addr] = wr_data;
      end else if (eg_rd) begin
         exp_addr = rd_addr;
         q_data.push_back(shadow[rd_addr]);
         q_due.push_back(cyc + 1 + RL);
      end
      #1;
   endtask

   task automatic check_reset_outputs();
      check("rst_rd_gnt", 32'(rd_gnt), 32'd0);
      check("rst_wr_gnt", 32'(wr_gnt), 32'd0);
      check("rst_ram_en", 32'(ram_en), 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
   endtask

   initial begin
      int nw, nv, ne;
      logic [15:0] s0;
      for (int i = 0; i < 65536; i++) begin
         shadow[i]  = 24'(i * 32'h010101) ^ 24'h5A5A5A;
         ram_mem[i] <= 24'(i * 32'h010101) ^ 24'h5A5A5A;
      end
      shadow[16'h0010]  = 24'hA1B2C3;
      ram_mem[16'h0010] <= 24'hA1B2C3;

      // power-on reset with both requests raised: grants must stay low
      rd_req = 1'b1;
      wr_req = 1'b1;
      #2;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      rd_req = 1'b0;
      wr_req = 1'b0;
      #1 rst = 1'b0;
      model_reset();

      // single read
      rd_req = 1'b1; rd_addr = 16'h0010;
      tick();
      rd_req = 1'b0;
      repeat (4) tick();

      // write then read of the same word
      wr_req = 1'b1; wr_addr = 16'h0400; wr_data = 24'h123456;
      tick();
      wr_req = 1'b0;
      rd_req = 1'b1; rd_addr = 16'h0400;
      tick();
      rd_req = 1'b0;
      repeat (4) tick();

      // continuous contention: 8 reads then 1 write, repeating
      s0 = stall; nw = 0;
      rd_req = 1'b1; wr_req = 1'b1;
      for (int i = 0; i < 27; i++) begin
         tick();
         if (seen_wr) nw++;
         if (acc_rd) rd_addr = 16'($urandom_range(0, 15));
         if (acc_wr) begin
            wr_addr = 16'($urandom_range(0, 15));
            wr_data = 24'($urandom);
         end
      end
      rd_req = 1'b0; wr_req = 1'b0;
      check("burst_writes", 32'(nw), 32'd3);
      check("burst_stall_delta", 32'(stall - s0), 32'd24);
      repeat (4) tick();

      // streaming reads 0..63
      nv = 0; ne = 0;
      rd_req = 1'b1;
      for (int i = 0; i < 67; i++) begin
         if (i == 64) rd_req = 1'b0;
         rd_addr = 16'(i);
         tick();
         if (seen_valid) nv++;
         if (seen_en) ne++;
      end
      check("stream_valids", 32'(nv), 32'd64);
      check("stream_enables", 32'(ne), 32'd64);
      repeat (2) tick();

      // reset in the cycle after a read acceptance
      rd_req = 1'b1; rd_addr = 16'h0010;
      tick();
      rst = 1'b1;
      #1;
      check_reset_outputs();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_hold_valid", 32'(rd_valid), 32'd0);
         check("rst_hold_gnt", 32'(rd_gnt), 32'd0);
      end
      @(posedge clk);
      rd_req = 1'b0;
      #1 rst = 1'b0;
      model_reset();
      repeat (4) tick();
      rd_req = 1'b1; rd_addr = 16'h0010;
      tick();
      rd_req = 1'b0;
      repeat (4) tick();

      // random traffic on a small address window to exercise read-after-write
      for (int i = 0; i < 3000; i++) begin
         if (!rd_req && $urandom_range(0, 2) == 0) begin
            rd_req  = 1'b1;
            rd_addr = 16'($urandom_range(0, 15));
         end
         if (!wr_req && $urandom_range(0, 2) == 0) begin
            wr_req  = 1'b1;
            wr_addr = 16'($urandom_range(0, 15));
            wr_data = 24'($urandom);
         end
         tick();
         if (acc_rd) rd_req = 1'b0;
         if (acc_wr) wr_req = 1'b0;
      end
      rd_req = 1'b0; wr_req = 1'b0;
      repeat (4) tick();

      // long contention drives the stall counter into saturation
      nw = 0;
      rd_req = 1'b1; wr_req = 1'b1;
      for (int i = 0; i < 74000; i++) begin
         tick();
         if (i >= 74000 - 18 && seen_wr) nw++;
         if (acc_rd) rd_addr = 16'($urandom_range(0, 15));
         if (acc_wr) begin
            wr_addr = 16'($urandom_range(0, 15));
            wr_data = 24'($urandom);
         end
      end
      rd_req = 1'b0; wr_req = 1'b0;
      check("stall_saturated", 32'(stall), 32'h0000FFFF);
      check("writes_after_sat", 32'(nw), 32'd2);
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
